// File: rtl/mips_muldiv_hilo_if.sv
// rtl/mips_muldiv_hilo_if.sv - issue/result bundle between the ALU issuer and the HI/LO mul/div unit
interface mips_muldiv_hilo_if;
    logic        start;
    logic [5:0]  funct;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, funct, op1, op2, input busy, done, hi, lo);
    modport slave  (input start, funct, op1, op2, output busy, done, hi, lo);
endinterface

// File: rtl/mips_muldiv_hilo.sv
// rtl/mips_muldiv_hilo.sv - iterative MIPS multiply/divide unit owning HI/LO
module mips_muldiv_hilo (
    input  logic              clk,
    input  logic              reset,
    mips_muldiv_hilo_if.slave bus
);

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic        is_div;
    logic        neg_q;      // result (product or quotient) is negated
    logic        neg_r;      // remainder takes the dividend's sign
    logic [31:0] m_opnd;     // multiplicand for multiply, divisor for divide
    logic [31:0] op1_lat;    // raw dividend, returned in HI on divide by zero
    logic [63:0] acc;        // multiply: {partial product, multiplier}; divide: low half is dividend/quotient
    logic [31:0] rem;
    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic        busy_r;
    logic        done_r;

    logic        op_signed;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic        div_qbit;
    logic [63:0] prod_neg;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    // Operand sign handling; 0x80000000 negates to itself, which is 2^31 read unsigned
    always_comb begin
        op_signed = (bus.funct == F_MULT) || (bus.funct == F_DIV);
        a_neg     = op_signed & bus.op1[31];
        b_neg     = op_signed & bus.op2[31];
        a_mag     = a_neg ? (~bus.op1 + 32'd1) : bus.op1;
        b_mag     = b_neg ? (~bus.op2 + 32'd1) : bus.op2;
    end

    // One shift-add or restoring-subtract step, plus the sign fix-ups used at FIN
    always_comb begin
        mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, m_opnd} : 33'd0);
        div_shift = {rem, acc[31]};
        div_diff  = div_shift - {1'b0, m_opnd};
        div_qbit  = ~div_diff[32];
        prod_neg  = ~acc + 64'd1;
        quo_fix   = neg_q ? (~acc[31:0] + 32'd1) : acc[31:0];
        rem_fix   = neg_r ? (~rem + 32'd1) : rem;
    end

    // Control FSM and datapath registers; HI/LO only change on MTHI/MTLO or at FIN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 5'd0;
            is_div  <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            m_opnd  <= 32'd0;
            op1_lat <= 32'd0;
            acc     <= 64'd0;
            rem     <= 32'd0;
            hi_r    <= 32'd0;
            lo_r    <= 32'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        case (bus.funct)
                            F_MTHI: hi_r <= bus.op1;
                            F_MTLO: lo_r <= bus.op1;
                            F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                                is_div  <= bus.funct[1];
                                neg_q   <= a_neg ^ b_neg;
                                neg_r   <= a_neg;
                                m_opnd  <= bus.funct[1] ? b_mag : a_mag;
                                op1_lat <= bus.op1;
                                acc     <= {32'd0, bus.funct[1] ? a_mag : b_mag};
                                rem     <= 32'd0;
                                cnt     <= 5'd0;
                                busy_r  <= 1'b1;
                                state   <= CALC;
                            end
                            default: ;
                        endcase
                    end
                end
                CALC: begin
                    if (is_div) begin
                        rem        <= div_qbit ? div_diff[31:0] : div_shift[31:0];
                        acc[31:0]  <= {acc[30:0], div_qbit};
                    end else begin
                        acc <= {mul_sum, acc[31:1]};
                    end
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state <= FIN;
                    end
                end
                FIN: begin
                    if (!is_div) begin
                        {hi_r, lo_r} <= neg_q ? prod_neg : acc;
                    end else if (m_opnd == 32'd0) begin
                        hi_r <= op1_lat;
                        lo_r <= 32'hFFFF_FFFF;
                    end else begin
                        hi_r <= rem_fix;
                        lo_r <= quo_fix;
                    end
                    done_r <= 1'b1;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;

endmodule

// File: tb/tb_mips_muldiv_hilo.sv
// tb/tb_mips_muldiv_hilo.sv - self-checking bench for mips_muldiv_hilo
module tb_mips_muldiv_hilo;

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_ADD   = 6'b100000;

    typedef struct {
        string       name;
        logic [5:0]  funct;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ehi;
        logic [31:0] elo;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    mips_muldiv_hilo_if bus ();

    mips_muldiv_hilo dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Architectural reference: plain signed/unsigned 64-bit arithmetic
    function automatic void ref_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] rh, output logic [31:0] rl);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        longint      q;
        longint      r;
        logic [63:0] p;
        rh = 32'd0;
        rl = 32'd0;
        case (f)
            F_MULT:  begin p = sa * sb; rh = p[63:32]; rl = p[31:0]; end
            F_MULTU: begin p = {32'd0, a} * {32'd0, b}; rh = p[63:32]; rl = p[31:0]; end
            F_DIV: begin
                if (b == 0) begin rh = a; rl = 32'hFFFF_FFFF; end
                else begin q = sa / sb; r = sa % sb; rl = q[31:0]; rh = r[31:0]; end
            end
            F_DIVU: begin
                if (b == 0) begin rh = a; rl = 32'hFFFF_FFFF; end
                else begin rl = a / b; rh = a % b; end
            end
            default: ;
        endcase
    endfunction

    // Issue one mul/div and observe 36 cycles after acceptance; optionally pulse a second start mid-flight
    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          input int inj_at, input logic [5:0] inj_f, input logic [31:0] inj_a,
                          output logic [31:0] ghi, output logic [31:0] glo,
                          output int nbusy, output int ndone, output int done_at, output int hold_bad);
        logic [31:0] phi;
        logic [31:0] plo;
        @(negedge clk);
        phi = bus.hi;
        plo = bus.lo;
        bus.start = 1'b1; bus.funct = f; bus.op1 = a; bus.op2 = b;
        @(negedge clk);
        bus.start = 1'b0;
        nbusy = 0; ndone = 0; done_at = -1; hold_bad = 0;
        ghi = 32'd0; glo = 32'd0;
        for (int k = 0; k < 36; k++) begin
            if (bus.busy) begin
                nbusy++;
                if (bus.hi !== phi || bus.lo !== plo) hold_bad++;
            end
            if (bus.done) begin
                ndone++;
                done_at = k;
                ghi = bus.hi;
                glo = bus.lo;
                if (bus.busy) hold_bad++;
            end
            if (k == inj_at) begin
                bus.start = 1'b1; bus.funct = inj_f; bus.op1 = inj_a; bus.op2 = 32'd0;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
    endtask

    task automatic check_op(input string nm, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] ehi, input logic [31:0] elo,
                            input int inj_at, input logic [5:0] inj_f, input logic [31:0] inj_a);
        logic [31:0] ghi;
        logic [31:0] glo;
        int nb;
        int nd;
        int da;
        int hb;
        run_op(f, a, b, inj_at, inj_f, inj_a, ghi, glo, nb, nd, da, hb);
        chk({nm, " hi"}, {32'd0, ghi}, {32'd0, ehi});
        chk({nm, " lo"}, {32'd0, glo}, {32'd0, elo});
        chk({nm, " busy_cycles"}, 64'(nb), 64'd33);
        chk({nm, " done_count"}, 64'(nd), 64'd1);
        chk({nm, " done_latency"}, 64'(da), 64'd33);
        chk({nm, " hold_during_busy"}, 64'(hb), 64'd0);
        m_hi = ehi;
        m_lo = elo;
    endtask

    // Single-cycle register move or ignored funct; result visible next cycle, never busy/done
    task automatic check_move(input string nm, input logic [5:0] f, input logic [31:0] a);
        @(negedge clk);
        bus.start = 1'b1; bus.funct = f; bus.op1 = a; bus.op2 = ~a;
        @(negedge clk);
        bus.start = 1'b0;
        if (f == F_MTHI) m_hi = a;
        if (f == F_MTLO) m_lo = a;
        chk({nm, " hi"}, {32'd0, bus.hi}, {32'd0, m_hi});
        chk({nm, " lo"}, {32'd0, bus.lo}, {32'd0, m_lo});
        chk({nm, " busy"}, {63'd0, bus.busy}, 64'd0);
        chk({nm, " done"}, {63'd0, bus.done}, 64'd0);
    endtask

    vec_t vecs[8];

    initial begin
        logic [31:0] rh;
        logic [31:0] rl;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [5:0]  rf;
        int          sel;

        vecs[0] = '{"multu_max",   F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1] = '{"mult_neg",    F_MULT,  32'hE2329B00, 32'd1000,     32'hFFFFFF8B, 32'h95AD7800};
        vecs[2] = '{"div_m7_2",    F_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3] = '{"div_ovf",     F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[4] = '{"div_7_m2",    F_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[5] = '{"mult_minsq",  F_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[6] = '{"div_by0",     F_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF};
        vecs[7] = '{"divu_by0",    F_DIVU,  32'd7,        32'd0,        32'h00000007, 32'hFFFFFFFF};

        bus.start = 1'b0; bus.funct = 6'd0; bus.op1 = 32'd0; bus.op2 = 32'd0;
        #12;
        chk("reset hi", {32'd0, bus.hi}, 64'd0);
        chk("reset lo", {32'd0, bus.lo}, 64'd0);
        chk("reset busy", {63'd0, bus.busy}, 64'd0);
        chk("reset done", {63'd0, bus.done}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            check_op(vecs[i].name, vecs[i].funct, vecs[i].a, vecs[i].b, vecs[i].ehi, vecs[i].elo, -1, 6'd0, 32'd0);
        end

        check_move("mthi_after_divu0", F_MTHI, 32'h12345678);

        check_op("multu_mtlo_ignored", F_MULTU, 32'd3, 32'd5, 32'd0, 32'h0000000F, 5, F_MTLO, 32'hAAAAAAAA);

        // Asynchronous reset mid-divide, asserted between edges
        @(negedge clk);
        bus.start = 1'b1; bus.funct = F_DIVU; bus.op1 = 32'd100; bus.op2 = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        chk("pre_reset busy", {63'd0, bus.busy}, 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_reset hi", {32'd0, bus.hi}, 64'd0);
        chk("async_reset lo", {32'd0, bus.lo}, 64'd0);
        chk("async_reset busy", {63'd0, bus.busy}, 64'd0);
        chk("async_reset done", {63'd0, bus.done}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        check_op("divu_after_reset", F_DIVU, 32'd100, 32'd7, 32'h00000002, 32'h0000000E, -1, 6'd0, 32'd0);

        // Randomized ops against the arithmetic reference
        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 6);
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 5) == 0) ra = 32'h80000000;
            if ($urandom_range(0, 5) == 0) rb = 32'd0;
            if ($urandom_range(0, 3) == 0) rb = {28'd0, rb[3:0]};
            if (sel <= 3) begin
                case (sel)
                    0: rf = F_MULT;
                    1: rf = F_MULTU;
                    2: rf = F_DIV;
                    default: rf = F_DIVU;
                endcase
                ref_op(rf, ra, rb, rh, rl);
                check_op($sformatf("rand%0d_f%b_%h_%h", n, rf, ra, rb), rf, ra, rb, rh, rl, -1, 6'd0, 32'd0);
            end else if (sel == 4) begin
                check_move($sformatf("rand%0d_mthi", n), F_MTHI, ra);
            end else if (sel == 5) begin
                check_move($sformatf("rand%0d_mtlo", n), F_MTLO, ra);
            end else begin
                check_move($sformatf("rand%0d_badfunct", n), F_ADD, ra);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_muldiv_hilo.md
# mips_muldiv_hilo

Iterative multiply/divide unit that owns the architectural HI/LO registers of the MIPS core. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO, which the single-cycle ALU dispatches with a start pulse. It holds HI/LO for MFHI/MFLO reads through its `hi`/`lo` outputs. A busy/done handshake lets the pipeline stall for the 33-cycle multi-cycle operations.

## Interface
- No parameters; datapath fixed at 32 bits, iteration count fixed at 32.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `start`  in  1  request; sampled only in IDLE.
- `funct`  in  6  R-type funct field:
  - MULT 011000
  - MULTU 011001
  - DIV 011010
  - DIVU 011011
  - MTHI 010001
  - MTLO 010011
- `op1`  in  32  rs value (multiplicand/dividend, or MTHI/MTLO source).
- `op2`  in  32  rt value (multiplier/divisor).
- `busy`  out  1  high while a multiply/divide is in progress.
- `done`  out  1  one-cycle pulse when HI/LO receive a mul/div result.
- `hi`  out  32  architectural HI register.
- `lo`  out  32  architectural LO register.

## Operation
- States: IDLE, CALC, FIN.
- Reset (any time, including mid-operation) forces the following, regardless of `clk`:
  - state=IDLE, `hi`=0, `lo`=0, `busy`=0, `done`=0;
  - iteration counter and internal operand registers cleared.
- IDLE with `start`=1:
  - MTHI: `hi`<=`op1` at that edge; stay IDLE; no busy, no done.
  - MTLO: `lo`<=`op1` at that edge; stay IDLE; no busy, no done.
  - MULT/MULTU/DIV/DIVU: latch operand magnitudes and sign flags, counter<=0, go to CALC.
  - Any other funct: ignored, stay IDLE.
- Operand magnitudes:
  - Signed ops (MULT, DIV) take two's-complement magnitudes; 0x80000000 yields magnitude 2^31 as an unsigned 32-bit value.
  - Unsigned ops use operands as-is.
- CALC: one iteration per cycle, 32 iterations (counter 0..31), then FIN.
  - Multiply: radix-2 shift-add into a 64-bit accumulator.
  - Divide: restoring, 33-bit partial remainder; one quotient bit per cycle, MSB first.
- FIN (one edge): sign-correct, write HI/LO, pulse `done`, return to IDLE.
  - Multiply: {hi,lo} <= product, 64-bit negated if op signs differ (MULT only).
  - Divide: lo <= quotient, negated if signs differ (DIV only); hi <= remainder, sign of dividend (DIV only).
  - Divide by zero (both DIV and DIVU): hi<=op1 as latched, lo<=32'hFFFFFFFF; same latency.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (falls out of the magnitude scheme, no special case needed).
- `start` during CALC/FIN is ignored, including MTHI/MTLO. The issuer must hold the instruction until `busy` falls.
- `hi`/`lo` hold their old values throughout CALC and change only at the FIN edge.

## Timing
- Let E0 be the edge at which a mul/div `start` is accepted.
- `busy`=1 in the cycles after E0 through E33, i.e. whenever state is not IDLE.
- CALC iterations occur at E1..E32; FIN is taken at E33.
- `hi`/`lo` hold the new result from E33 onward.
- `done`=1 for exactly the one cycle following E33; `busy`=0 in that same cycle.
- A new `start` is accepted at the first edge after E33 (back-to-back throughput of 34 cycles).
- MTHI/MTLO: single-cycle write at the accepting edge; the value is visible the following cycle.
- `busy` and `done` are registered outputs (no combinational path from `start`).

## Test plan
- MULTU op1=FFFFFFFF, op2=FFFFFFFF -> after 33 cycles hi=FFFFFFFE, lo=00000001; `done` pulses once; `busy` high for exactly 33 cycles.
- MULT op1=-500000000 (E2329B00), op2=1000 -> hi=FFFFFF8B, lo=95AD7800.
- Signed divide corner cases:
  - DIV op1=-7 (FFFFFFF9), op2=2 -> lo=FFFFFFFD, hi=FFFFFFFF.
  - DIV 80000000/FFFFFFFF -> lo=80000000, hi=00000000.
- DIVU op1=7, op2=0 -> hi=00000007, lo=FFFFFFFF, `done` at normal latency. Then MTHI 12345678 -> hi=12345678 next cycle, lo unchanged, no `done`.
- Start MULTU 3*5, pulse MTLO AAAAAAAA at cycle 5 -> MTLO ignored; final lo=0000000F, hi=0.
- Start DIVU 100/7, assert `reset` asynchronously at cycle 10 between clock edges -> hi=lo=0, `busy`=0 immediately. After release, DIVU 100/7 -> lo=0000000E, hi=00000002.
